// File: rtl/button_debouncer.sv
// Debounces an active-low push-button: 2-flop synchronizer, stability counter, 4-state FSM.
// Long-press pulse detection is built only when BUTTON_DEBOUNCER_LONG_PRESS_EN is defined.
module button_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned LONG_CYCLES     = 50000000,
    parameter int unsigned LONG_W          = 26
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic button_ni,
    output logic button_no,
    output logic bouncing_o,
    output logic long_press_o
);

    // Bit 1 = accepted level is "pressed", bit 0 = qualifying a change.
    // Each output is therefore a single flop, with no decode glitches.
    typedef enum logic [1:0] {
        RELEASED    = 2'b00,
        ARM_PRESS   = 2'b01,
        PRESSED     = 2'b10,
        ARM_RELEASE = 2'b11
    } state_e;

    localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);

    logic [1:0]       sync_q;
    logic             s;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= 2'b11;
        else         sync_q <= {sync_q[0], button_ni};
    end

    assign s = sync_q[1];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RELEASED;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            RELEASED: begin
                if (!s) begin
                    state_d = ARM_PRESS;
                    cnt_d   = CNT_W'(1);
                end
            end
            ARM_PRESS: begin
                if (s) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_CNT) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            PRESSED: begin
                if (s) begin
                    state_d = ARM_RELEASE;
                    cnt_d   = CNT_W'(1);
                end
            end
            ARM_RELEASE: begin
                if (!s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_CNT) begin
                    state_d = RELEASED;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
        endcase
    end

    always_comb begin
        button_no  = ~state_q[1];
        bouncing_o = state_q[0];
    end

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] long_q, long_inc;
    logic              long_pulse_q;

    assign long_inc = long_q + LONG_W'(1);

    // Counter holds through ARM_RELEASE so a bounce back to PRESSED keeps counting,
    // and saturates at LONG_MAX to give one pulse per press.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            long_q       <= '0;
            long_pulse_q <= 1'b0;
        end else begin
            long_pulse_q <= 1'b0;
            unique case (state_q)
                PRESSED: begin
                    if (long_q != LONG_MAX) begin
                        long_q       <= long_inc;
                        long_pulse_q <= (long_inc == LONG_MAX);
                    end
                end
                ARM_RELEASE: long_q <= long_q;
                default:     long_q <= '0;
            endcase
        end
    end

    assign long_press_o = long_pulse_q;
`else
    assign long_press_o = 1'b0;
`endif

endmodule
